// File: rtl/rv_muldiv_unit.sv
// RISC-V M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, one op in flight.
// Latency: div special cases 1, multiply MUL_STAGES+1, divide/remainder N+2 (N = XLEN or XLEN/2).
// Backpressure: the result is held in DONE until resp_ready; req_ready is low whenever busy or flushing.
//
// Ports:
//   clk, rst (async, active-high), flush (synchronous abort of the in-flight op)
//   req_valid/req_ready/req_op/req_a/req_b/req_tag     : request channel, funct3 op encoding
//   resp_valid/resp_ready/resp_result/resp_tag         : response channel, tag returned unchanged
module rv_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_RADIX4 = 0,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag
);

    localparam int N_ITER = (DIV_RADIX4 != 0) ? XLEN / 2 : XLEN;
    localparam int CNT_W  = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_ITER);
    localparam logic [CNT_W-1:0] M_LAST  = CNT_W'(MUL_STAGES);
    localparam logic [XLEN-1:0]  MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_ITER, S_DIV_FIX, S_DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               q_neg_q;
    logic               r_neg_q;
    logic [2*XLEN-1:0]  prod_q [MUL_STAGES];
    logic [XLEN-1:0]    div_r_q;
    logic [XLEN-1:0]    div_q_q;
    logic [XLEN-1:0]    div_d_q;
    logic               resp_valid_q;
    logic [XLEN-1:0]    resp_result_q;
    logic [TAG_W-1:0]   resp_tag_q;

    logic [2*XLEN-1:0]  mul_a_ext, mul_b_ext, prod_d;
    logic               div_signed, a_neg, b_neg, div_special;
    logic [XLEN-1:0]    abs_a, abs_b, special_res;
    logic [XLEN-1:0]    q_fix, r_fix, mul_sel;
    logic [2*XLEN-1:0]  div_next_d;

    // One restoring step: shift the next dividend bit into the partial remainder and
    // subtract the divisor if it fits. Packed result is {remainder, quotient/dividend}.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r,
                                                   input logic [XLEN-1:0] q,
                                                   input logic [XLEN-1:0] d);
        logic [XLEN:0]   r_sh;
        logic [XLEN:0]   diff;
        logic [XLEN-1:0] q_sh;
        r_sh = {r, q[XLEN-1]};
        q_sh = {q[XLEN-2:0], 1'b0};
        diff = r_sh - {1'b0, d};
        if (!diff[XLEN]) begin
            r_sh    = diff;
            q_sh[0] = 1'b1;
        end
        return {r_sh[XLEN-1:0], q_sh};
    endfunction

    // Operands are extended to 2*XLEN so one unsigned multiplier covers all four
    // signedness combinations (the truncated product is exact modulo 2^(2*XLEN)).
    always_comb begin
        mul_a_ext = (req_op[1:0] == 2'd1 || req_op[1:0] == 2'd2) ?
                    {{XLEN{req_a[XLEN-1]}}, req_a} : {{XLEN{1'b0}}, req_a};
        mul_b_ext = (req_op[1:0] == 2'd1) ?
                    {{XLEN{req_b[XLEN-1]}}, req_b} : {{XLEN{1'b0}}, req_b};
        prod_d    = mul_a_ext * mul_b_ext;

        div_signed  = !req_op[0];
        a_neg       = div_signed & req_a[XLEN-1];
        b_neg       = div_signed & req_b[XLEN-1];
        abs_a       = a_neg ? -req_a : req_a;
        abs_b       = b_neg ? -req_b : req_b;
        div_special = (req_b == '0) || (div_signed && req_a == MIN_INT && req_b == '1);
        if (req_b == '0) special_res = req_op[1] ? req_a : '1;
        else             special_res = req_op[1] ? '0 : MIN_INT;

        q_fix   = q_neg_q ? -div_q_q : div_q_q;
        r_fix   = r_neg_q ? -div_r_q : div_r_q;
        mul_sel = (op_q == 2'd0) ? prod_q[MUL_STAGES-1][XLEN-1:0]
                                 : prod_q[MUL_STAGES-1][2*XLEN-1:XLEN];
    end

    if (DIV_RADIX4 != 0) begin : g_radix4
        logic [2*XLEN-1:0] s1;
        assign s1         = div_step(div_r_q, div_q_q, div_d_q);
        assign div_next_d = div_step(s1[2*XLEN-1:XLEN], s1[XLEN-1:0], div_d_q);
    end else begin : g_radix2
        assign div_next_d = div_step(div_r_q, div_q_q, div_d_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            tag_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            div_r_q       <= '0;
            div_q_q       <= '0;
            div_d_q       <= '0;
            for (int i = 0; i < MUL_STAGES; i++) prod_q[i] <= '0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_tag_q    <= '0;
        end else if (flush) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    op_q  <= req_op[1:0];
                    tag_q <= req_tag;
                    cnt_q <= CNT_W'(1);
                    if (!req_op[2]) begin
                        prod_q[0] <= prod_d;
                        state_q   <= S_MUL;
                    end else if (div_special) begin
                        resp_result_q <= special_res;
                        resp_tag_q    <= req_tag;
                        resp_valid_q  <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        div_r_q <= '0;
                        div_q_q <= abs_a;
                        div_d_q <= abs_b;
                        q_neg_q <= a_neg ^ b_neg;
                        r_neg_q <= a_neg;
                        state_q <= S_DIV_ITER;
                    end
                end
                S_MUL: begin
                    for (int i = 1; i < MUL_STAGES; i++) prod_q[i] <= prod_q[i-1];
                    if (cnt_q == M_LAST) begin
                        resp_result_q <= mul_sel;
                        resp_tag_q    <= tag_q;
                        resp_valid_q  <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DIV_ITER: begin
                    {div_r_q, div_q_q} <= div_next_d;
                    if (cnt_q == N_LAST) state_q <= S_DIV_FIX;
                    else                 cnt_q   <= cnt_q + 1'b1;
                end
                S_DIV_FIX: begin
                    resp_result_q <= op_q[1] ? r_fix : q_fix;
                    resp_tag_q    <= tag_q;
                    resp_valid_q  <= 1'b1;
                    state_q       <= S_DONE;
                end
                S_DONE: if (resp_ready) begin
                    resp_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE) && !flush;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_tag    = resp_tag_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Bench for rv_muldiv_unit: instance 0 uses defaults (MUL_STAGES=2, radix-2),
// instance 1 uses MUL_STAGES=3 and radix-4 division.
// Table vectors, hand-written corner sequences and random ops against a plain-arithmetic model.
module tb_rv_muldiv_unit;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush       [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [2:0]  req_op      [2];
    logic [31:0] req_a       [2];
    logic [31:0] req_b       [2];
    logic [4:0]  req_tag     [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [31:0] resp_result [2];
    logic [4:0]  resp_tag    [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .DIV_RADIX4(0), .TAG_W(5)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_tag(req_tag[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_result(resp_result[0]), .resp_tag(resp_tag[0])
    );

    rv_muldiv_unit #(.XLEN(32), .MUL_STAGES(3), .DIV_RADIX4(1), .TAG_W(5)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_tag(req_tag[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_result(resp_result[1]), .resp_tag(resp_tag[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result from the ISA definition using wide integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      pa, pb;
        logic [63:0] p;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin pa = longint'(sa); pb = longint'(sb); p = pa * pb; return p[63:32]; end
            3'd2: begin pa = longint'(sa); pb = longint'({32'b0, b}); p = pa * pb; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input int u, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        int ms, n;
        ms = (u == 0) ? 2 : 3;
        n  = (u == 0) ? 32 : 16;
        if (op < 3'd4) return ms + 1;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return n + 2;
    endfunction

    // Issue one op, measure latency, check result/tag, optionally hold resp_ready low.
    task automatic run_op(input int u, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp_res, input int exp_lat,
                          input int hold, input string name);
        int lat;
        @(negedge clk);
        chk({name, " req_ready"}, req_ready[u], 1);
        req_valid[u]  = 1'b1;
        req_op[u]     = op;
        req_a[u]      = a;
        req_b[u]      = b;
        req_tag[u]    = tag;
        resp_ready[u] = (hold == 0);
        @(posedge clk);
        #1;
        // scramble the request bus; the unit must not look at it while busy
        req_valid[u] = 1'b0;
        req_op[u]    = 3'($urandom);
        req_a[u]     = $urandom;
        req_b[u]     = $urandom;
        req_tag[u]   = 5'($urandom);
        lat = 1;
        while (!resp_valid[u] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, resp_result[u], exp_res);
        chk({name, " tag"}, resp_tag[u], tag);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " held {valid,req_ready,tag,result}"},
                {resp_valid[u], req_ready[u], resp_tag[u], resp_result[u]},
                {1'b1, 1'b0, tag, exp_res});
        end
        @(negedge clk);
        resp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        chk({name, " taken {valid,req_ready}"}, {resp_valid[u], req_ready[u]}, 2'b01);
    endtask

    initial begin
        vec_t        vecs[14];
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel, hold;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 3};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 3};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 3};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF, 3};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         5'd7,  32'd14,        34};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         34};
        vecs[8]  = '{3'd4, 32'h55,         32'd0,         5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'h1234,       32'd0,         5'd10, 32'h1234,      1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1};
        vecs[12] = '{3'd5, 32'd9,          32'd0,         5'd13, 32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         5'd14, 32'hFFFF_FFF9, 1};

        for (int u = 0; u < 2; u++) begin
            flush[u] = 1'b0; req_valid[u] = 1'b0; req_op[u] = '0; req_a[u] = '0;
            req_b[u] = '0; req_tag[u] = '0; resp_ready[u] = 1'b1;
        end

        // reset values, checked while reset is held
        #2 rst = 1'b1;
        #20;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset u%0d resp_valid", u), resp_valid[u], 0);
            chk($sformatf("reset u%0d resp_result", u), resp_result[u], 0);
            chk($sformatf("reset u%0d resp_tag", u), resp_tag[u], 0);
            chk($sformatf("reset u%0d req_ready", u), req_ready[u], 1);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res,
                   vecs[i].lat, 0, $sformatf("vec%0d", i));

        // radix-4 / 3-stage multiply instance
        run_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFD, 18, 0, "r4 DIV");
        run_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd18, 32'hFFFF_FFEB, 4, 0, "ms3 MUL");

        // backpressure: result and tag must stay put for 10 cycles
        run_op(0, 3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 34, 10, "backpressure");

        // flush at iteration 10 with a simultaneous request
        @(negedge clk);
        req_valid[0] = 1'b1; req_op[0] = 3'd4; req_a[0] = 32'hFFFF_FFF9;
        req_b[0] = 32'd2; req_tag[0] = 5'd20;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b1; req_valid[0] = 1'b1; req_op[0] = 3'd0;
        req_a[0] = 32'd7; req_b[0] = 32'hFFFF_FFFD; req_tag[0] = 5'd21;
        #1 chk("flush req_ready", req_ready[0], 0);
        @(posedge clk);
        #1;
        flush[0] = 1'b0; req_valid[0] = 1'b0;
        chk("flush resp_valid", resp_valid[0], 0);
        run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd21, 32'hFFFF_FFEB, 3, 0, "post-flush MUL");

        // reset in the middle of a division
        @(negedge clk);
        req_valid[0] = 1'b1; req_op[0] = 3'd5; req_a[0] = 32'd1000;
        req_b[0] = 32'd3; req_tag[0] = 5'd22;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midop rst {valid,req_ready}", {resp_valid[0], req_ready[0]}, 2'b01);
        chk("midop rst result", resp_result[0], 0);
        chk("midop rst tag", resp_tag[0], 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 3'd7, 32'd1000, 32'd3, 5'd23, 32'd1, 34, 0, "post-rst REMU");

        // random ops against the reference model
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 60; k++) begin
                op  = 3'($urandom);
                a   = $urandom;
                b   = $urandom;
                sel = $urandom_range(0, 5);
                case (sel)
                    0: b = 32'd0;
                    1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    2: b = $urandom_range(1, 15);
                    3: a = $urandom_range(0, 100);
                    default: ;
                endcase
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                run_op(u, op, a, b, 5'($urandom), ref_res(op, a, b), ref_lat(u, op, a, b),
                       hold, $sformatf("rand u%0d #%0d op%0d", u, k, op));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
